// File: rtl/vram_access_master.sv
// -----------------------------------------------------------------------------
// vram_access_master
//
// Bus initiator for single 8-bit read/write cycles into the video RAM window.
// A transaction walks IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
// - SETUP drives the address and write data with no strobe asserted.
// - STROBE asserts n_we or n_oe until the synchronised ready line grants
//   access, or until the timeout expires.
// - HOLD releases the strobe and keeps the bus stable for one more cycle.
// Every output is registered.
//
// Ports
//   clk     : system clock, rising edge
//   n_rst   : asynchronous active-low reset
//   req     : start request, sampled in IDLE only
//   we      : 1 = write, 0 = read (latched with req)
//   addr    : target address (latched with req)
//   wdata   : write data (latched with req)
//   busy    : high from SETUP through HOLD
//   done    : one-cycle completion pulse in the first IDLE cycle
//   err     : valid with done, 1 = transaction timed out
//   rdata   : read data, updated on a successful read only
//   a       : bus address
//   n_we    : active-low write strobe
//   n_oe    : active-low read strobe
//   d_out   : bus write data
//   d_oe    : 1 = drive d_out onto the bus
//   d_in    : bus read data
//   n_rdy   : active-low ready from the VGA controller (asynchronous)
// -----------------------------------------------------------------------------
module vram_access_master #(
   parameter int SYNC_STAGES = 2,
   parameter int STROBE_MIN  = 2,
   parameter int TIMEOUT     = 1023
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  rdata,
   output logic [15:0] a,
   output logic        n_we,
   output logic        n_oe,
   output logic [7:0]  d_out,
   output logic        d_oe,
   input  logic [7:0]  d_in,
   input  logic        n_rdy
);

   localparam logic [15:0] LP_MIN = 16'(STROBE_MIN);
   localparam logic [15:0] LP_TMO = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } state_t;

   state_t      r_state, w_state_next;
   logic [15:0] r_cnt, w_cnt_next;
   logic        r_we, w_we_next;
   logic        r_tmo, w_tmo_next;
   logic [15:0] r_a, w_a_next;
   logic [7:0]  r_dout, w_dout_next;
   logic        r_doe, w_doe_next;
   logic        r_nwe, w_nwe_next;
   logic        r_noe, w_noe_next;
   logic        r_busy, w_busy_next;
   logic        r_done, w_done_next;
   logic        r_err, w_err_next;
   logic [7:0]  r_rdata, w_rdata_next;

   // n_rdy synchroniser: stage 0 samples the pin, each later stage samples
   // the one before it. Every stage idles at 1 (not ready).
   logic [SYNC_STAGES-1:0] r_sync;
   logic [SYNC_STAGES-1:0] w_sync_d;
   logic                   w_rdy_s;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign w_sync_d[gi] = n_rdy;
         end else begin : g_chain
            assign w_sync_d[gi] = r_sync[gi-1];
         end
      end
   endgenerate

   assign w_rdy_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_sync <= '1;
      end else begin
         r_sync <= w_sync_d;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_tmo   <= 1'b0;
         r_a     <= '0;
         r_dout  <= '0;
         r_doe   <= 1'b0;
         r_nwe   <= 1'b1;
         r_noe   <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_we    <= w_we_next;
         r_tmo   <= w_tmo_next;
         r_a     <= w_a_next;
         r_dout  <= w_dout_next;
         r_doe   <= w_doe_next;
         r_nwe   <= w_nwe_next;
         r_noe   <= w_noe_next;
         r_busy  <= w_busy_next;
         r_done  <= w_done_next;
         r_err   <= w_err_next;
         r_rdata <= w_rdata_next;
      end
   end

   // Next state and next output values. Because the outputs are registered,
   // each branch computes what the bus should show in the *following* state.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_we_next    = r_we;
      w_tmo_next   = r_tmo;
      w_a_next     = r_a;
      w_dout_next  = r_dout;
      w_doe_next   = r_doe;
      w_nwe_next   = 1'b1;
      w_noe_next   = 1'b1;
      w_busy_next  = r_busy;
      w_done_next  = 1'b0;
      w_err_next   = 1'b0;
      w_rdata_next = r_rdata;

      unique case (r_state)
         ST_IDLE: begin
            w_busy_next = 1'b0;
            w_doe_next  = 1'b0;
            w_cnt_next  = '0;
            if (req) begin
               w_state_next = ST_SETUP;
               w_we_next    = we;
               w_tmo_next   = 1'b0;
               w_a_next     = addr;
               w_doe_next   = we;
               w_busy_next  = 1'b1;
               if (we) begin
                  w_dout_next = wdata;
               end
            end
         end

         ST_SETUP: begin
            // Strobe goes active one cycle after the address settled.
            w_state_next = ST_STROBE;
            w_cnt_next   = 16'd1;
            w_nwe_next   = ~r_we;
            w_noe_next   = r_we;
         end

         ST_STROBE: begin
            if ((r_cnt >= LP_MIN) && !w_rdy_s) begin
               w_state_next = ST_HOLD;
               if (!r_we) begin
                  w_rdata_next = d_in;
               end
            end else if (r_cnt == LP_TMO) begin
               w_state_next = ST_HOLD;
               w_tmo_next   = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 16'd1;
               w_nwe_next = ~r_we;
               w_noe_next = r_we;
            end
         end

         ST_HOLD: begin
            // Address and data stay put through HOLD; they are released
            // (d_oe dropped) on entry to IDLE together with the done pulse.
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
            w_err_next   = r_tmo;
            w_busy_next  = 1'b0;
            w_doe_next   = 1'b0;
            w_cnt_next   = '0;
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign busy  = r_busy;
   assign done  = r_done;
   assign err   = r_err;
   assign rdata = r_rdata;
   assign a     = r_a;
   assign n_we  = r_nwe;
   assign n_oe  = r_noe;
   assign d_out = r_dout;
   assign d_oe  = r_doe;

endmodule

// File: tb/tb_vram_access_master.sv
// -----------------------------------------------------------------------------
// tb_vram_access_master
//
// Two instances: dut1 with default parameters, dut2 with TIMEOUT=8 for the
// timeout scenario. A select bit routes req to one instance and picks which
// instance's outputs the checks look at. Expected strobe lengths come from the
// ready-latency rule: a release after r strobe cycles becomes visible
// SYNC_STAGES cycles later, bounded below by STROBE_MIN and above by TIMEOUT.
// -----------------------------------------------------------------------------
module tb_vram_access_master;

   localparam int SS   = 2;
   localparam int SMIN = 2;
   localparam int TO1  = 1023;
   localparam int TO2  = 8;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        req, we;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic [7:0]  d_in;
   logic        n_rdy;
   bit          sel;

   logic        req1, req2;
   logic        busy1, done1, err1, n_we1, n_oe1, d_oe1;
   logic [7:0]  rdata1, d_out1;
   logic [15:0] a1;
   logic        busy2, done2, err2, n_we2, n_oe2, d_oe2;
   logic [7:0]  rdata2, d_out2;
   logic [15:0] a2;

   logic        m_busy, m_done, m_err, m_n_we, m_n_oe, m_d_oe;
   logic [7:0]  m_rdata, m_d_out;
   logic [15:0] m_a;

   int n_chk  = 0;
   int n_pass = 0;
   logic [7:0] model_rdata [2];

   always #5 clk = ~clk;

   assign req1 = req & ~sel;
   assign req2 = req & sel;

   assign m_busy  = sel ? busy2  : busy1;
   assign m_done  = sel ? done2  : done1;
   assign m_err   = sel ? err2   : err1;
   assign m_n_we  = sel ? n_we2  : n_we1;
   assign m_n_oe  = sel ? n_oe2  : n_oe1;
   assign m_d_oe  = sel ? d_oe2  : d_oe1;
   assign m_rdata = sel ? rdata2 : rdata1;
   assign m_d_out = sel ? d_out2 : d_out1;
   assign m_a     = sel ? a2     : a1;

   vram_access_master #(.SYNC_STAGES(SS), .STROBE_MIN(SMIN), .TIMEOUT(TO1)) dut1 (
      .clk(clk), .n_rst(n_rst), .req(req1), .we(we), .addr(addr), .wdata(wdata),
      .busy(busy1), .done(done1), .err(err1), .rdata(rdata1), .a(a1),
      .n_we(n_we1), .n_oe(n_oe1), .d_out(d_out1), .d_oe(d_oe1),
      .d_in(d_in), .n_rdy(n_rdy)
   );

   vram_access_master #(.SYNC_STAGES(SS), .STROBE_MIN(SMIN), .TIMEOUT(TO2)) dut2 (
      .clk(clk), .n_rst(n_rst), .req(req2), .we(we), .addr(addr), .wdata(wdata),
      .busy(busy2), .done(done2), .err(err2), .rdata(rdata2), .a(a2),
      .n_we(n_we2), .n_oe(n_oe2), .d_out(d_out2), .d_oe(d_oe2),
      .d_in(d_in), .n_rdy(n_rdy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction. rel < 0: bus already ready. rel >= 0: n_rdy is
   // released at the start of strobe cycle rel+1.
   task automatic run_txn(input logic t_we, input logic [15:0] t_addr,
                          input logic [7:0] t_wdata, input logic [7:0] t_din,
                          input int rel, input string tag);
      int  to;
      int  exp_k;
      bit  exp_err;
      int  n_str;
      bit  hold_seen;
      bit  strobe_on;
      to = sel ? TO2 : TO1;
      if (rel < 0) exp_k = SMIN;
      else exp_k = (rel + 1 + SS > SMIN) ? rel + 1 + SS : SMIN;
      exp_err = (exp_k > to);
      if (exp_err) exp_k = to;

      n_rdy = (rel < 0) ? 1'b0 : 1'b1;
      d_in  = t_din;
      repeat (3) step();
      req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
      step();
      // SETUP cycle; scramble the request inputs, which must now be ignored
      req = 1'b0; we = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
      chk({tag, " setup busy"}, 32'(m_busy), 32'd1);
      chk({tag, " setup a"}, 32'(m_a), 32'(t_addr));
      chk({tag, " setup strobes"}, {30'd0, m_n_we, m_n_oe}, 32'd3);
      chk({tag, " setup d_oe"}, 32'(m_d_oe), 32'(t_we));
      if (t_we) chk({tag, " setup d_out"}, 32'(m_d_out), 32'(t_wdata));

      n_str = 0;
      hold_seen = 1'b0;
      for (int j = 0; j < 2000 && !hold_seen; j++) begin
         step();
         strobe_on = t_we ? !m_n_we : !m_n_oe;
         if (strobe_on) begin
            n_str++;
            if (t_we) chk({tag, " strobe n_oe"}, 32'(m_n_oe), 32'd1);
            else      chk({tag, " strobe n_we"}, 32'(m_n_we), 32'd1);
            chk({tag, " strobe a"}, 32'(m_a), 32'(t_addr));
            chk({tag, " strobe d_oe"}, 32'(m_d_oe), 32'(t_we));
            if (n_str == rel + 1) n_rdy = 1'b0;
         end else begin
            hold_seen = 1'b1;
         end
      end
      chk({tag, " strobe ended"}, 32'(hold_seen), 32'd1);
      chk({tag, " strobe cycles"}, 32'(n_str), 32'(exp_k));

      if (!t_we && !exp_err) model_rdata[sel] = t_din;
      // HOLD cycle
      chk({tag, " hold strobes"}, {30'd0, m_n_we, m_n_oe}, 32'd3);
      chk({tag, " hold busy"}, 32'(m_busy), 32'd1);
      chk({tag, " hold a"}, 32'(m_a), 32'(t_addr));
      chk({tag, " hold d_oe"}, 32'(m_d_oe), 32'(t_we));
      chk({tag, " hold done"}, 32'(m_done), 32'd0);
      chk({tag, " hold rdata"}, 32'(m_rdata), 32'(model_rdata[sel]));
      step();
      chk({tag, " done"}, 32'(m_done), 32'd1);
      chk({tag, " err"}, 32'(m_err), 32'(exp_err));
      chk({tag, " idle busy"}, 32'(m_busy), 32'd0);
      chk({tag, " idle d_oe"}, 32'(m_d_oe), 32'd0);
      chk({tag, " idle a"}, 32'(m_a), 32'(t_addr));
      if (t_we) chk({tag, " idle d_out"}, 32'(m_d_out), 32'(t_wdata));
      step();
      chk({tag, " done clear"}, {30'd0, m_done, m_err}, 32'd0);
      $display("txn %s: we=%0b addr=%h strobe=%0d err=%0b rdata=%h",
               tag, t_we, t_addr, n_str, m_err, m_rdata);
   endtask

   initial begin : main
      logic [15:0] ba [3];
      logic [7:0]  bw [3];
      int          dones;
      int          tr, ph;
      n_rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      d_in = '0; n_rdy = 1'b1; sel = 1'b0;
      model_rdata[0] = '0; model_rdata[1] = '0;

      repeat (3) step();
      chk("reset a", 32'(a1), 32'd0);
      chk("reset strobes", {30'd0, n_we1, n_oe1}, 32'd3);
      chk("reset flags", {28'd0, busy1, done1, err1, d_oe1}, 32'd0);
      chk("reset data", {16'd0, rdata1, d_out1}, 32'd0);
      n_rst = 1'b1;
      step();

      // Write with bus already ready
      run_txn(1'b1, 16'hF000, 8'hA5, 8'h00, -1, "write_rdy");
      // Read stalled for 20 strobe cycles
      run_txn(1'b0, 16'hE010, 8'h00, 8'h3C, 20, "read_stall");

      // Randomised transactions on the default instance
      for (int i = 0; i < 10; i++) begin
         int r;
         r = int'($urandom_range(0, 11)) - 1;
         run_txn(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), r, "random");
      end

      // Timeout instance: a good read first, then one that times out
      sel = 1'b1;
      run_txn(1'b0, 16'h1234, 8'h00, 8'h5A, -1, "to_preload");
      run_txn(1'b0, 16'h4321, 8'h00, 8'hC3, 100, "timeout");
      sel = 1'b0;

      // Back-to-back with req held high
      for (int i = 0; i < 3; i++) begin
         ba[i] = 16'($urandom);
         bw[i] = 8'($urandom);
      end
      n_rdy = 1'b0;
      repeat (3) step();
      req = 1'b1; we = 1'b1; addr = ba[0]; wdata = bw[0];
      dones = 0;
      for (int t = 1; t <= 15; t++) begin
         step();
         tr = (t - 1) / 5;
         ph = (t - 1) % 5;
         chk("b2b a", 32'(a1), 32'(ba[tr]));
         chk("b2b d_out", 32'(d_out1), 32'(bw[tr]));
         chk("b2b done", 32'(done1), 32'(ph == 4));
         chk("b2b n_we", 32'(n_we1), 32'(!(ph == 1 || ph == 2)));
         chk("b2b busy", 32'(busy1), 32'(ph < 4));
         if (done1) dones++;
         if (t == 15) begin
            req = 1'b0;
         end else if (ph == 4) begin
            addr = ba[tr+1]; wdata = bw[tr+1];
         end else begin
            addr = 16'($urandom); wdata = 8'($urandom);
         end
      end
      chk("b2b done count", 32'(dones), 32'd3);
      $display("txn b2b: done pulses=%0d", dones);

      // Reset in the second strobe cycle of a stalled write
      n_rdy = 1'b1;
      repeat (3) step();
      req = 1'b1; we = 1'b1; addr = 16'hBEEF; wdata = 8'h77;
      step();
      req = 1'b0;
      step();
      step();
      chk("rst_mid n_we before", 32'(n_we1), 32'd0);
      n_rst = 1'b0;
      #1;
      chk("rst_mid n_we", 32'(n_we1), 32'd1);
      chk("rst_mid d_oe", 32'(d_oe1), 32'd0);
      chk("rst_mid busy", 32'(busy1), 32'd0);
      chk("rst_mid a", 32'(a1), 32'd0);
      model_rdata[0] = '0; model_rdata[1] = '0;
      step();
      n_rst = 1'b1;
      dones = 0;
      for (int t = 0; t < 10; t++) begin
         step();
         if (done1 || busy1 || !n_we1 || !n_oe1) dones++;
      end
      chk("rst_mid stays idle", 32'(dones), 32'd0);
      chk("rst_mid rdata", 32'(rdata1), 32'(model_rdata[0]));
      $display("txn reset_mid_strobe: activity after release=%0d", dones);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
